// File: rtl/sram_controller.sv
// sram_controller: MEM-stage responder that splits each 32-bit access into
// two timed 16-bit accesses on an external asynchronous SRAM.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        ST_val,
    output logic [31:0]        MEM_read_value,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_out,
    input  logic [15:0]        SRAM_DQ_in,
    output logic               SRAM_DQ_oe,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               op_wr;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        st_q;
    logic [31:0]        phys;
    logic               req, busy, last;
    logic               unused_phys;

    assign phys        = ALU_result - 32'(BASE_ADDR);
    assign unused_phys = ^{phys[31:SRAM_AW+1], phys[1:0]};
    assign req         = MEM_W_EN | MEM_R_EN;
    assign busy        = (state == LOW) || (state == HIGH);
    assign last        = (cnt == LAST);

    // State and per-half cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, half-access timing and ready
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready   = !req;
                cnt_nxt = '0;
                if (req) state_nxt = LOW;
            end
            LOW: begin
                if (last) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HIGH: begin
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the request so the SRAM pins never see the live pipeline inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr  <= 1'b0;
            word_q <= '0;
            st_q   <= '0;
        end else if (state == IDLE && req) begin
            op_wr  <= MEM_W_EN;
            word_q <= phys[SRAM_AW:2];
            st_q   <= ST_val;
        end
    end

    // Capture each read half on the last cycle it is held on the pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MEM_read_value <= '0;
        end else if (busy && !op_wr && last) begin
            if (state == LOW) MEM_read_value[15:0]  <= SRAM_DQ_in;
            else              MEM_read_value[31:16] <= SRAM_DQ_in;
        end
    end

    // Pin decode from state and latched registers; WE_N has a one-cycle
    // setup high at the start of each half unless a half is one cycle long
    always_comb begin
        SRAM_ADDR   = {word_q, state == HIGH};
        SRAM_DQ_out = (state == HIGH) ? st_q[31:16] : st_q[15:0];
        SRAM_DQ_oe  = busy && op_wr;
        SRAM_WE_N   = !(busy && op_wr && ((WAIT_CYCLES == 1) || (cnt != 4'd0)));
        SRAM_OE_N   = !(busy && !op_wr);
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: scoreboarded bench with a behavioural async SRAM.
module tb_sram_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
    logic [31:0] ALU_result = '0, ST_val = '0;
    logic [31:0] MEM_read_value;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
    logic        SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int oe_low = 0;
    logic we_prev = 1'b1;

    logic [15:0] mem [0:15] = '{default: 16'h0};
    logic [31:0] ref_mem [0:7] = '{default: 32'h0};
    logic [31:0] sb [$];

    sram_controller dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_result(ALU_result), .ST_val(ST_val), .MEM_read_value(MEM_read_value),
        .ready(ready), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out),
        .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_OE_N(SRAM_OE_N)
    );

    always #5 clk = ~clk;

    // Async SRAM: reads follow OE_N, writes land while WE_N is low
    assign SRAM_DQ_in = !SRAM_OE_N ? mem[SRAM_ADDR[3:0]] : 16'h0;

    always @(negedge clk) begin
        if (!SRAM_WE_N && SRAM_DQ_oe) mem[SRAM_ADDR[3:0]] <= SRAM_DQ_out;
        if (!SRAM_WE_N && we_prev) pulses <= pulses + 1;
        if (!SRAM_OE_N) oe_low <= oe_low + 1;
        we_prev <= SRAM_WE_N;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full access; returns at the DONE cycle with enables dropped
    task automatic do_access(input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input string tag);
        int n, p0, o0, w;
        @(negedge clk);
        p0 = pulses;
        o0 = oe_low;
        w  = int'((addr - 32'd1024) >> 2) & 7;
        MEM_W_EN = wr; MEM_R_EN = !wr; ALU_result = addr; ST_val = data;
        if (wr) ref_mem[w] = data;
        else    sb.push_back(ref_mem[w]);
        #1;
        n = 0;
        while (!ready && n < 50) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk({tag, " latency"}, n, 5);
        if (!wr) begin
            if (sb.size() != 0) chk({tag, " rdata"}, MEM_read_value, sb.pop_front());
            else chk({tag, " sb empty"}, 32'd1, 32'd0);
        end
        chk({tag, " we pulses"}, pulses - p0, wr ? 2 : 0);
        chk({tag, " oe cycles"}, oe_low - o0, wr ? 0 : 4);
        MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst ready", ready, 1);
        chk("rst rdata", MEM_read_value, 0);
        chk("rst pins", {SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe}, 3'b110);
        chk("rst addr", SRAM_ADDR, 0);
        chk("rst dq", SRAM_DQ_out, 0);
        @(negedge clk);
        rst = 1'b1;

        // Idle: nothing moves
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("idle", {ready, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe}, 4'b1110);
        end

        do_access(1'b1, 32'd1024, 32'hDEADBEEF, "st0");
        chk("mem0", mem[0], 16'hBEEF);
        chk("mem1", mem[1], 16'hDEAD);
        do_access(1'b0, 32'd1024, 32'h0, "ld0");

        do_access(1'b1, 32'd1028, 32'h12345678, "st1");
        chk("mem2", mem[2], 16'h5678);
        chk("mem3", mem[3], 16'h1234);
        do_access(1'b0, 32'd1030, 32'h0, "ld1");

        // Back-to-back store then load, rdata must persist across a write
        do_access(1'b1, 32'd1036, 32'hA5A55A5A, "st2");
        chk("rdata held", MEM_read_value, 32'h12345678);
        do_access(1'b0, 32'd1036, 32'h0, "ld2");
        do_access(1'b0, 32'd1024, 32'h0, "ld3");

        // Reset during the HIGH half of a store
        @(negedge clk);
        MEM_W_EN = 1'b1; ALU_result = 32'd1032; ST_val = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        #1;
        chk("pre-rst high", SRAM_ADDR[0], 1'b1);
        rst = 1'b0;
        #1;
        chk("mid-rst we_n", SRAM_WE_N, 1'b1);
        chk("mid-rst oe", SRAM_DQ_oe, 1'b0);
        chk("mid-rst idle", ready, 1'b0);
        MEM_W_EN = 1'b0;
        #1;
        chk("mid-rst ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("post-rst ready", ready, 1'b1);
        chk("post-rst rdata", MEM_read_value, 32'h0);
        chk("partial low", mem[4], 16'hF00D);
        chk("partial high", mem[5], 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
Memory-side responder for the MEM stage. It accepts the stage's read/write enables, address (the ALU result) and store value. Each 32-bit access is carried out as two sequenced 16-bit accesses to an external asynchronous SRAM. While an access is in flight it deasserts ready so the pipeline freezes, then returns the loaded word to the MEM stage register.

Parameters:
BASE_ADDR, 1024, byte address that maps to SRAM word 0; subtracted from the incoming address
WAIT_CYCLES, 2, clock cycles each 16-bit half-access is held on the SRAM pins (legal range 1..15)
SRAM_AW, 18, SRAM address width (16-bit locations)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
MEM_R_EN  in  1  load request from MEM stage; held high while ready=0
MEM_W_EN  in  1  store request from MEM stage; held high while ready=0
ALU_result  in  32  byte address of the access
ST_val  in  32  store data
MEM_read_value  out  32  loaded word
ready  out  1  0 = freeze pipeline; 1 = access complete or idle
SRAM_ADDR  out  SRAM_AW  SRAM location address
SRAM_DQ_out  out  16  write data to SRAM
SRAM_DQ_in  in  16  read data from SRAM
SRAM_DQ_oe  out  1  1 = drive SRAM_DQ_out onto the bus
SRAM_WE_N  out  1  SRAM write strobe, active-low
SRAM_OE_N  out  1  SRAM output enable, active-low

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counter 0, MEM_read_value=0, SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0, SRAM_WE_N=1, SRAM_OE_N=1.
- Address map: phys = ALU_result - BASE_ADDR (32-bit, wraps modulo 2^32); word = phys[SRAM_AW:2]; low half at SRAM_ADDR={word,0}, high half at {word,1}. phys[1:0] is ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: if MEM_W_EN or MEM_R_EN, latch op, address and ST_val, then go to LOW. If both are asserted, write wins.
- LOW: drive the low-half address for WAIT_CYCLES cycles, then go to HIGH.
  - Write: SRAM_DQ_oe=1, SRAM_DQ_out=ST_val[15:0], SRAM_WE_N=0.
  - Read: SRAM_OE_N=0; capture SRAM_DQ_in into MEM_read_value[15:0] on the last cycle.
- HIGH: same as LOW using the high-half address and bits [31:16]. Then go to DONE.
- DONE: all SRAM strobes inactive; go to IDLE unconditionally. The held request is not re-accepted in DONE.
- ready (combinational): 1 in DONE; 1 in IDLE when neither enable is asserted; 0 otherwise.
- Latency: request first seen in IDLE at cycle 0; ready=1 in cycle 2*WAIT_CYCLES+1. With the default that is ready low for 5 cycles and high in cycle 5.
- SRAM pins are decoded from state and latched registers only. There is no combinational path from the request inputs to SRAM pins.
- SRAM_WE_N is high on the first cycle of each half-write (setup) and low for the remaining WAIT_CYCLES-1 cycles. When WAIT_CYCLES=1, SRAM_WE_N is low for the whole cycle.
- MEM_read_value holds its last loaded value across writes and idle periods. It is updated only by reads.
- Enables dropping mid-access is a protocol violation. The access still completes.
- Reset mid-operation: immediate return to IDLE with strobes inactive. A partially written word is not rolled back.

Test Plan:
- Idle: no enables for 10 cycles -> ready=1 throughout, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0.
- Store: MEM_W_EN=1, ALU_result=1024, ST_val=0xDEADBEEF, WAIT_CYCLES=2 -> SRAM model location 0=0xBEEF, location 1=0xDEAD; ready=0 for cycles 0-4, ready=1 at cycle 5.
- Load: MEM_R_EN=1, ALU_result=1024 after the store -> MEM_read_value=0xDEADBEEF when ready rises; SRAM_OE_N low only during LOW/HIGH.
- Mapping: store 0x12345678 to ALU_result=1028 -> locations 2=0x5678, 3=0x1234. A load from 1030 returns 0x12345678 (low bits ignored).
- Back-to-back: store, then a load the cycle after DONE -> second access starts immediately with no lost or duplicated access. Exactly two SRAM write pulses, one per half.
- Reset mid-write: assert rst=0 during HIGH -> SRAM_WE_N=1 and state IDLE asynchronously. After release with no request, ready=1 and MEM_read_value=0.
